// File: rtl/pulse_destretcher_pkg.sv
// Shared pulse-link definitions: state encodings and default stretch constants used by both link ends.
// No timing or flow-control content; purely types and constants.
package pulse_destretcher_pkg;

    localparam int STRX_DEFAULT        = 18;
    localparam int TOL_DEFAULT         = 2;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HIGH     = 2'd2
    } state_e;

endpackage

// File: rtl/pulse_destretcher_bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous bit; latency STAGES cycles.
// No backpressure: samples d every cycle unconditionally.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_destretcher.sv
// Measures a stretched (possibly async) pulse and emits a one-cycle strobe or error; strobe 2 cycles after first low sample.
// No backpressure: pulse_out/pulse_err are one-cycle strobes the consumer must take when they fire.
module pulse_destretcher
    import pulse_destretcher_pkg::*;
#(
    parameter int STRX        = STRX_DEFAULT,
    parameter int TOL         = TOL_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int CW          = $clog2(STRX + TOL + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          din,
    output logic          pulse_out,
    output logic          pulse_err,
    output logic [CW-1:0] width_q,
    output logic          busy
);

    localparam logic [CW-1:0] MAX_CNT = CW'(STRX + TOL);
    localparam logic [CW-1:0] MIN_CNT = CW'(STRX - TOL);
    localparam logic [CW-1:0] SAT_CNT = CW'(STRX + TOL + 1);

    logic din_s;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_din_sync (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (din_s)
    );

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          width_d;
    logic [SYNC_STAGES-1:0] prime_q, prime_d;
    logic                   pulse_out_q, pulse_out_d;
    logic                   pulse_err_q, pulse_err_d;
    logic                   busy_q, busy_d;
    logic                   primed;

    // The synchronizer comes out of reset holding zeros, not real samples of din;
    // WAIT_LOW ignores din_s until it has been refilled so a pulse that spans reset is not re-measured.
    assign primed = prime_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        width_d     = width_q;
        pulse_out_d = 1'b0;
        pulse_err_d = 1'b0;
        prime_d     = {prime_q[SYNC_STAGES-2:0], 1'b1};

        case (state_q)
            ST_WAIT_LOW: begin
                if (primed && !din_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (din_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = CW'(1);
                end
            end
            ST_HIGH: begin
                if (din_s) begin
                    if (cnt_q == MAX_CNT) begin
                        pulse_err_d = 1'b1;
                        width_d     = SAT_CNT;
                        cnt_d       = '0;
                        state_d     = ST_WAIT_LOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // cnt never exceeds MAX_CNT here, so only the lower bound needs testing.
                    width_d     = cnt_q;
                    pulse_out_d = (cnt_q >= MIN_CNT);
                    pulse_err_d = (cnt_q < MIN_CNT);
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_WAIT_LOW;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_WAIT_LOW;
            cnt_q       <= '0;
            width_q     <= '0;
            prime_q     <= '0;
            pulse_out_q <= 1'b0;
            pulse_err_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            prime_q     <= prime_d;
            pulse_out_q <= pulse_out_d;
            pulse_err_q <= pulse_err_d;
            busy_q      <= busy_d;
        end
    end

    assign pulse_out = pulse_out_q;
    assign pulse_err = pulse_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pulse_destretcher.sv
// Directed bench for pulse_destretcher: nominal, boundary, overlong, back-to-back and mid-pulse reset cases.
module tb_pulse_destretcher;

    localparam int STRX = 18;
    localparam int TOL  = 2;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          din;
    logic          pulse_out;
    logic          pulse_err;
    logic [CW-1:0] width_q;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic          pat[$];
    logic          po_tr[$];
    logic          pe_tr[$];
    logic          bz_tr[$];
    logic [CW-1:0] wq_tr[$];

    always #5 clk = ~clk;

    pulse_destretcher #(
        .STRX        (STRX),
        .TOL         (TOL),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .pulse_out (pulse_out),
        .pulse_err (pulse_err),
        .width_q   (width_q),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_seg(input logic lvl, input int n);
        repeat (n) pat.push_back(lvl);
    endtask

    // Drives pat[i] before edge i and records the outputs 1 ns after that edge at index i.
    task automatic play();
        po_tr.delete();
        pe_tr.delete();
        bz_tr.delete();
        wq_tr.delete();
        for (int s = 0; s < pat.size(); s++) begin
            din = pat[s];
            step();
            po_tr.push_back(pulse_out);
            pe_tr.push_back(pulse_err);
            bz_tr.push_back(busy);
            wq_tr.push_back(width_q);
        end
        pat.delete();
    endtask

    function automatic int count_ones(input logic q[$]);
        int c = 0;
        foreach (q[i]) if (q[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_one(input logic q[$]);
        foreach (q[i]) if (q[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic test_reset();
        logic strobe_seen;
        reset = 1'b0;
        din   = 1'b0;
        repeat (5) step();
        total++; if (pulse_out !== 1'b0) begin bad++; $display("FAIL reset_pulse_out got=%b want=0", pulse_out); end
        total++; if (pulse_err !== 1'b0) begin bad++; $display("FAIL reset_pulse_err got=%b want=0", pulse_err); end
        total++; if (width_q !== 5'd0) begin bad++; $display("FAIL reset_width got=%0d want=0", width_q); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
        reset = 1'b1;
        step();
        strobe_seen = pulse_out | pulse_err;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL release_busy_hold got=%b want=1", busy); end
        step();
        strobe_seen |= pulse_out | pulse_err;
        step();
        strobe_seen |= pulse_out | pulse_err;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy_low got=%b want=0", busy); end
        total++; if (strobe_seen !== 1'b0) begin bad++; $display("FAIL release_no_strobe got=%b want=0", strobe_seen); end
    endtask

    task automatic test_nominal();
        add_seg(1'b1, 18);
        add_seg(1'b0, 8);
        play();
        total++; if (count_ones(po_tr) != 1) begin bad++; $display("FAIL nominal_out_count got=%0d want=1", count_ones(po_tr)); end
        total++; if (count_ones(pe_tr) != 0) begin bad++; $display("FAIL nominal_err_count got=%0d want=0", count_ones(pe_tr)); end
        total++; if (first_one(po_tr) != 20) begin bad++; $display("FAIL nominal_latency got=%0d want=20", first_one(po_tr)); end
        total++; if (wq_tr[wq_tr.size()-1] !== 5'd18) begin bad++; $display("FAIL nominal_width got=%0d want=18", wq_tr[wq_tr.size()-1]); end
        total++; if (bz_tr[bz_tr.size()-1] !== 1'b0) begin bad++; $display("FAIL nominal_busy_end got=%b want=0", bz_tr[bz_tr.size()-1]); end
    endtask

    task automatic test_boundaries();
        int widths[4]  = '{16, 20, 15, 21};
        int exp_ok[4]  = '{1, 1, 0, 0};
        int exp_idx[4] = '{18, 22, 17, 22};
        int got_idx;
        for (int k = 0; k < 4; k++) begin
            add_seg(1'b1, widths[k]);
            add_seg(1'b0, 8);
            play();
            got_idx = (exp_ok[k] != 0) ? first_one(po_tr) : first_one(pe_tr);
            total++; if (count_ones(po_tr) != exp_ok[k]) begin bad++; $display("FAIL bound_w%0d_out_count got=%0d want=%0d", widths[k], count_ones(po_tr), exp_ok[k]); end
            total++; if (count_ones(pe_tr) != 1 - exp_ok[k]) begin bad++; $display("FAIL bound_w%0d_err_count got=%0d want=%0d", widths[k], count_ones(pe_tr), 1 - exp_ok[k]); end
            total++; if (got_idx != exp_idx[k]) begin bad++; $display("FAIL bound_w%0d_latency got=%0d want=%0d", widths[k], got_idx, exp_idx[k]); end
            total++; if (wq_tr[wq_tr.size()-1] !== CW'(widths[k])) begin bad++; $display("FAIL bound_w%0d_width got=%0d want=%0d", widths[k], wq_tr[wq_tr.size()-1], widths[k]); end
        end
    endtask

    task automatic test_overlong();
        add_seg(1'b1, 100);
        add_seg(1'b0, 6);
        play();
        total++; if (count_ones(pe_tr) != 1) begin bad++; $display("FAIL long_err_count got=%0d want=1", count_ones(pe_tr)); end
        total++; if (count_ones(po_tr) != 0) begin bad++; $display("FAIL long_out_count got=%0d want=0", count_ones(po_tr)); end
        total++; if (first_one(pe_tr) != 22) begin bad++; $display("FAIL long_err_index got=%0d want=22", first_one(pe_tr)); end
        total++; if (wq_tr[wq_tr.size()-1] !== 5'd21) begin bad++; $display("FAIL long_width got=%0d want=21", wq_tr[wq_tr.size()-1]); end
        total++; if (bz_tr[50] !== 1'b1) begin bad++; $display("FAIL long_busy_mid got=%b want=1", bz_tr[50]); end
        total++; if (bz_tr[101] !== 1'b1) begin bad++; $display("FAIL long_busy_before_fall got=%b want=1", bz_tr[101]); end
        total++; if (bz_tr[102] !== 1'b0) begin bad++; $display("FAIL long_busy_after_fall got=%b want=0", bz_tr[102]); end
    endtask

    task automatic test_back_to_back();
        add_seg(1'b1, 1);
        add_seg(1'b0, 1);
        add_seg(1'b1, 18);
        add_seg(1'b0, 8);
        play();
        total++; if (count_ones(pe_tr) != 1) begin bad++; $display("FAIL b2b_err_count got=%0d want=1", count_ones(pe_tr)); end
        total++; if (first_one(pe_tr) != 3) begin bad++; $display("FAIL b2b_err_index got=%0d want=3", first_one(pe_tr)); end
        total++; if (wq_tr[3] !== 5'd1) begin bad++; $display("FAIL b2b_glitch_width got=%0d want=1", wq_tr[3]); end
        total++; if (count_ones(po_tr) != 1) begin bad++; $display("FAIL b2b_out_count got=%0d want=1", count_ones(po_tr)); end
        total++; if (first_one(po_tr) != 22) begin bad++; $display("FAIL b2b_out_index got=%0d want=22", first_one(po_tr)); end
        total++; if (wq_tr[wq_tr.size()-1] !== 5'd18) begin bad++; $display("FAIL b2b_width got=%0d want=18", wq_tr[wq_tr.size()-1]); end
    endtask

    task automatic test_reset_mid_pulse();
        logic strobe_seen = 1'b0;
        logic busy_dropped = 1'b0;
        din = 1'b1;
        repeat (8) step();
        reset = 1'b0;
        #1;
        total++; if (width_q !== 5'd0) begin bad++; $display("FAIL midrst_width_clear got=%0d want=0", width_q); end
        total++; if ((pulse_out | pulse_err) !== 1'b0) begin bad++; $display("FAIL midrst_strobe_clear got=%b want=0", pulse_out | pulse_err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy got=%b want=1", busy); end
        step();
        reset = 1'b1;
        repeat (21) begin
            step();
            strobe_seen |= pulse_out | pulse_err;
            if (busy !== 1'b1) busy_dropped = 1'b1;
        end
        din = 1'b0;
        repeat (2) begin
            step();
            strobe_seen |= pulse_out | pulse_err;
            if (busy !== 1'b1) busy_dropped = 1'b1;
        end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_after_fall got=%b want=0", busy); end
        repeat (3) begin
            step();
            strobe_seen |= pulse_out | pulse_err;
        end
        total++; if (busy_dropped !== 1'b0) begin bad++; $display("FAIL midrst_busy_hold got=%b want=0", busy_dropped); end
        total++; if (strobe_seen !== 1'b0) begin bad++; $display("FAIL midrst_no_strobe got=%b want=0", strobe_seen); end
        total++; if (width_q !== 5'd0) begin bad++; $display("FAIL midrst_width_kept got=%0d want=0", width_q); end
        add_seg(1'b1, 18);
        add_seg(1'b0, 8);
        play();
        total++; if (count_ones(po_tr) != 1) begin bad++; $display("FAIL midrst_next_out got=%0d want=1", count_ones(po_tr)); end
        total++; if (wq_tr[wq_tr.size()-1] !== 5'd18) begin bad++; $display("FAIL midrst_next_width got=%0d want=18", wq_tr[wq_tr.size()-1]); end
    endtask

    initial begin
        reset = 1'b0;
        din   = 1'b0;
        test_reset();
        test_nominal();
        test_boundaries();
        test_overlong();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
